// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
// Performs WIDTH-bit additions through one external 4-bit adder slice, one
// nibble per clock, LSB nibble first. The carry between nibbles is held in a
// register. Operands arrive on a valid/ready input and the registered result
// leaves on a valid/ready output.
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_cin,
    output logic [3:0]       adder_a,
    output logic [3:0]       adder_b,
    output logic             adder_cin,
    input  logic [3:0]       adder_sum,
    input  logic             adder_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy
);

    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             last_nib;

    assign last_nib = (idx == IDX_W'(NIB - 1));

    // Next-state decode and handshake/adder outputs; everything is forced low while in reset.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        adder_a   = 4'h0;
        adder_b   = 4'h0;
        adder_cin = 1'b0;
        if (rst_n) begin
            case (state)
                S_IDLE: begin
                    in_ready = 1'b1;
                    if (in_valid) state_nxt = S_RUN;
                end
                S_RUN: begin
                    busy      = 1'b1;
                    adder_a   = a_reg[4*idx +: 4];
                    adder_b   = b_reg[4*idx +: 4];
                    adder_cin = carry;
                    if (last_nib) state_nxt = S_DONE;
                end
                S_DONE: begin
                    busy      = 1'b1;
                    out_valid = 1'b1;
                    if (out_ready) state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Operand capture, nibble-by-nibble result assembly and carry threading.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx      <= '0;
            carry    <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            out_sum  <= '0;
            out_cout <= 1'b0;
            out_ovf  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_reg   <= op_a;
                        b_reg   <= op_b;
                        carry   <= op_cin;
                        idx     <= '0;
                        out_sum <= '0;
                    end
                end
                S_RUN: begin
                    out_sum[4*idx +: 4] <= adder_sum;
                    carry               <= adder_cout;
                    if (last_nib) begin
                        // The top nibble's sum bit 3 is the result MSB.
                        out_cout <= adder_cout;
                        out_ovf  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                    (adder_sum[3] != a_reg[WIDTH-1]);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
